alu_exec: RTL and testbench

- Multi-cycle execute stage of the tiny CPU; sits directly downstream of the decoder and wraps around the 8x8 register file.
- Accepts one decoded operation at a time over a valid/ready handshake.
- Reads the source register through the register file's combinational read port and computes against an internal 8-bit accumulator.
- Writes results back through the register file's write port; owns the accumulator and the carry/zero flags.

---
 rtl/tiny_cpu_pkg.sv | 30 +++
 rtl/alu_core.sv | 106 ++++++++++
 rtl/alu_exec.sv | 133 +++++++++++++
 tb/tb_alu_exec.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_cpu_pkg.sv
// Shared widths, opcode encoding and execute-stage state type for the tiny CPU.
package tiny_cpu_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;

   typedef enum logic [3:0] {
      OP_NOP = 4'h0,
      OP_LD  = 4'h1,
      OP_ST  = 4'h2,
      OP_ADD = 4'h3,
      OP_SUB = 4'h4,
      OP_AND = 4'h5,
      OP_OR  = 4'h6,
      OP_XOR = 4'h7,
      OP_LDI = 4'h8,
      OP_ADC = 4'h9,
      OP_SHL = 4'hA,
      OP_SHR = 4'hB,
      OP_MUL = 4'hC
   } opcode_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } exec_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU for the execute stage: result, flags and update enables per opcode.
// Opcode C is an unsigned 8x8 multiply only when ALU_EXEC_MUL_EN is defined.
module alu_core
   import tiny_cpu_pkg::*;
(
   input  logic [3:0]        opcode,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] operand,
   input  logic [DATA_W-1:0] imm,
   input  logic              carry,
   output logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] result_hi,
   output logic              carry_new,
   output logic              zero_new,
   output logic              carry_upd,
   output logic              acc_upd,
   output logic              wb,
   output logic              illegal
);

   logic [DATA_W:0] sum;
`ifdef ALU_EXEC_MUL_EN
   logic [2*DATA_W-1:0] prod;
`endif

   always_comb begin
      sum       = '0;
`ifdef ALU_EXEC_MUL_EN
      prod      = '0;
`endif
      result    = acc;
      result_hi = '0;
      carry_new = carry;
      carry_upd = 1'b0;
      acc_upd   = 1'b0;
      wb        = 1'b0;
      illegal   = 1'b0;
      case (opcode)
         OP_NOP: ;
         OP_LD: begin
            result  = operand;
            acc_upd = 1'b1;
         end
         OP_ST: wb = 1'b1;
         OP_ADD: begin
            sum       = {1'b0, acc} + {1'b0, operand};
            result    = sum[DATA_W-1:0];
            carry_new = sum[DATA_W];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
         OP_SUB: begin
            // bit DATA_W of the widened difference is the borrow
            sum       = {1'b0, acc} - {1'b0, operand};
            result    = sum[DATA_W-1:0];
            carry_new = sum[DATA_W];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
         OP_AND, OP_OR, OP_XOR: begin
            result    = (opcode == OP_AND) ? (acc & operand) :
                        (opcode == OP_OR)  ? (acc | operand) : (acc ^ operand);
            carry_new = 1'b0;
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
         OP_LDI: begin
            result  = imm;
            acc_upd = 1'b1;
         end
         OP_ADC: begin
            sum       = {1'b0, acc} + {1'b0, operand} + {{DATA_W{1'b0}}, carry};
            result    = sum[DATA_W-1:0];
            carry_new = sum[DATA_W];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
         OP_SHL: begin
            result    = {acc[DATA_W-2:0], 1'b0};
            carry_new = acc[DATA_W-1];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
         OP_SHR: begin
            result    = {1'b0, acc[DATA_W-1:1]};
            carry_new = acc[0];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
         end
`ifdef ALU_EXEC_MUL_EN
         OP_MUL: begin
            prod      = {{DATA_W{1'b0}}, acc} * {{DATA_W{1'b0}}, operand};
            result    = prod[DATA_W-1:0];
            result_hi = prod[2*DATA_W-1:DATA_W];
            carry_new = |prod[2*DATA_W-1:DATA_W];
            carry_upd = 1'b1;
            acc_upd   = 1'b1;
            wb        = 1'b1;
         end
`endif
         default: illegal = 1'b1;
      endcase
      zero_new = (result == '0);
   end

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle execute stage: accepts one decoded op, reads the register file, updates acc/flags
// and optionally writes back. ALU_EXEC_MUL_EN enables the MUL opcode (C) with a high-byte writeback.
//
// state | meaning
// IDLE  | ready for an op; handshake latches fields and the source address
// READ  | capture operand from the register file read port
// EXEC  | update acc/flags; ST/MUL go on to WB
// WB    | register file write of latched rd
module alu_exec
   import tiny_cpu_pkg::*;
(
   input  logic              clk_in,
   input  logic              reset_in,
   input  logic              op_valid_in,
   output logic              op_ready_out,
   input  logic [3:0]        opcode_in,
   input  logic [ADDR_W-1:0] rs_in,
   input  logic [ADDR_W-1:0] rd_in,
   input  logic [DATA_W-1:0] imm_in,
   output logic [ADDR_W-1:0] rf_read_addr_out,
   input  logic [DATA_W-1:0] rf_read_data_in,
   output logic [ADDR_W-1:0] rf_write_addr_out,
   output logic              rf_write_en_out,
   output logic [DATA_W-1:0] rf_write_data_out,
   output logic [DATA_W-1:0] acc_out,
   output logic              carry_out,
   output logic              zero_out,
   output logic              done_out,
   output logic              illegal_out
);

   exec_state_t       state_q, state_d;
   logic [3:0]        opcode_q;
   logic [ADDR_W-1:0] rs_q, rd_q;
   logic [DATA_W-1:0] imm_q, operand_q, acc_q, wdata_q;
   logic              carry_q, zero_q, done_q, illegal_q;

   logic [DATA_W-1:0] alu_result, alu_hi;
   logic              alu_carry, alu_zero, alu_carry_upd, alu_acc_upd, alu_wb, alu_illegal;

   alu_core u_alu_core (
      .opcode    (opcode_q),
      .acc       (acc_q),
      .operand   (operand_q),
      .imm       (imm_q),
      .carry     (carry_q),
      .result    (alu_result),
      .result_hi (alu_hi),
      .carry_new (alu_carry),
      .zero_new  (alu_zero),
      .carry_upd (alu_carry_upd),
      .acc_upd   (alu_acc_upd),
      .wb        (alu_wb),
      .illegal   (alu_illegal)
   );

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d         = state_q;
      op_ready_out    = 1'b0;
      rf_write_en_out = 1'b0;
      case (state_q)
         IDLE: begin
            op_ready_out = 1'b1;
            if (op_valid_in) state_d = READ;
         end
         READ: state_d = EXEC;
         EXEC: state_d = alu_wb ? WB : IDLE;
         WB: begin
            rf_write_en_out = 1'b1;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         opcode_q  <= '0;
         rs_q      <= '0;
         rd_q      <= '0;
         imm_q     <= '0;
         operand_q <= '0;
         acc_q     <= '0;
         wdata_q   <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (op_valid_in) begin
                  opcode_q <= opcode_in;
                  rs_q     <= rs_in;
                  rd_q     <= rd_in;
                  imm_q    <= imm_in;
               end
            end
            READ: operand_q <= rf_read_data_in;
            EXEC: begin
               if (alu_acc_upd) begin
                  acc_q  <= alu_result;
                  zero_q <= alu_zero;
               end
               if (alu_carry_upd) carry_q <= alu_carry;
               // ST writes the pre-EXEC acc; MUL writes the product high byte
               wdata_q   <= (opcode_q == OP_MUL) ? alu_hi : acc_q;
               done_q    <= ~alu_wb;
               illegal_q <= alu_illegal;
            end
            WB: done_q <= 1'b1;
            default: ;
         endcase
      end
   end

   assign rf_read_addr_out  = rs_q;
   assign rf_write_addr_out = rd_q;
   assign rf_write_data_out = wdata_q;
   assign acc_out           = acc_q;
   assign carry_out         = carry_q;
   assign zero_out          = zero_q;
   assign done_out          = done_q;
   assign illegal_out       = illegal_q;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: register-file model, op-level reference model and per-cycle compare.
module tb_alu_exec;

   logic       clk_in = 1'b0;
   logic       reset_in = 1'b1;
   logic       op_valid_in = 1'b0;
   logic       op_ready_out;
   logic [3:0] opcode_in = '0;
   logic [2:0] rs_in = '0, rd_in = '0;
   logic [7:0] imm_in = '0;
   logic [2:0] rf_read_addr_out, rf_write_addr_out;
   logic [7:0] rf_read_data_in, rf_write_data_out, acc_out;
   logic       rf_write_en_out, carry_out, zero_out, done_out, illegal_out;

   always #5 clk_in = ~clk_in;

   alu_exec dut (
      .clk_in(clk_in), .reset_in(reset_in), .op_valid_in(op_valid_in), .op_ready_out(op_ready_out),
      .opcode_in(opcode_in), .rs_in(rs_in), .rd_in(rd_in), .imm_in(imm_in),
      .rf_read_addr_out(rf_read_addr_out), .rf_read_data_in(rf_read_data_in),
      .rf_write_addr_out(rf_write_addr_out), .rf_write_en_out(rf_write_en_out),
      .rf_write_data_out(rf_write_data_out), .acc_out(acc_out), .carry_out(carry_out),
      .zero_out(zero_out), .done_out(done_out), .illegal_out(illegal_out)
   );

   // register file attached to the DUT
   logic [7:0] rf [8];
   assign rf_read_data_in = rf[rf_read_addr_out];
   always @(posedge clk_in) if (rf_write_en_out) rf[rf_write_addr_out] <= rf_write_data_out;

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // reference model: architectural state plus the one in-flight op
   int  m_acc = 0, m_c = 0, m_z = 0;
   int  mregs [8];
   bit  act = 0;
   int  p_cyc, p_wb, p_ill, p_rs;
   int  e_acc, e_c, e_z, e_waddr, e_wdata;

   task automatic model_op(input int op, input int rs, input int rd, input int imm);
      int v, a, c, z, s, p;
      v = mregs[rs]; a = m_acc; c = m_c; z = m_z;
      p_wb = 0; p_ill = 0; p_rs = rs; e_waddr = rd; e_wdata = 0;
      case (op)
         0: ;
         1: begin a = v; z = (a == 0); end
         2: begin p_wb = 1; e_wdata = a; end
         3: begin s = a + v; c = (s > 255); a = s % 256; z = (a == 0); end
         4: begin c = (a < v); a = (a - v + 256) % 256; z = (a == 0); end
         5: begin a = a & v; c = 0; z = (a == 0); end
         6: begin a = a | v; c = 0; z = (a == 0); end
         7: begin a = a ^ v; c = 0; z = (a == 0); end
         8: begin a = imm; z = (a == 0); end
         9: begin s = a + v + c; c = (s > 255); a = s % 256; z = (a == 0); end
         10: begin c = (a >= 128); a = (a * 2) % 256; z = (a == 0); end
         11: begin c = a % 2; a = a / 2; z = (a == 0); end
`ifdef ALU_EXEC_MUL_EN
         12: begin p = a * v; a = p % 256; e_wdata = p / 256; c = (e_wdata != 0); z = (a == 0); p_wb = 1; end
`endif
         default: p_ill = 1;
      endcase
      e_acc = a; e_c = c; e_z = z;
   endtask

   always @(negedge clk_in) begin
      bit we_exp, done_exp;
      if (reset_in) begin
         act = 0; m_acc = 0; m_c = 0; m_z = 0;
         chk("rst_ready", op_ready_out, 1);
         chk("rst_we", rf_write_en_out, 0);
         chk("rst_done", done_out, 0);
         chk("rst_illegal", illegal_out, 0);
         chk("rst_acc", acc_out, 0);
         chk("rst_flags", {carry_out, zero_out}, 0);
         chk("rst_waddr", rf_write_addr_out, 0);
         chk("rst_wdata", rf_write_data_out, 0);
         chk("rst_raddr", rf_read_addr_out, 0);
      end else begin
         if (act && cyc == p_cyc + 2) begin
            m_acc = e_acc; m_c = e_c; m_z = e_z;
         end
         if (act && cyc == p_cyc) chk("read_addr", rf_read_addr_out, p_rs);
         done_exp = act && (cyc == p_cyc + 2 + p_wb);
         we_exp   = act && p_wb && (cyc == p_cyc + 2);
         chk("done", done_out, done_exp);
         chk("illegal", illegal_out, done_exp && p_ill);
         chk("write_en", rf_write_en_out, we_exp);
         chk("ready", op_ready_out, !(act && cyc < p_cyc + 2 + p_wb));
         if (we_exp) begin
            chk("write_addr", rf_write_addr_out, e_waddr);
            chk("write_data", rf_write_data_out, e_wdata);
         end
         chk("acc", acc_out, m_acc);
         chk("carry", carry_out, m_c);
         chk("zero", zero_out, m_z);
         if (done_exp) begin
            if (p_wb) mregs[e_waddr] = e_wdata;
            act = 0;
         end
         if (op_valid_in && op_ready_out) begin
            model_op(int'(opcode_in), int'(rs_in), int'(rd_in), int'(imm_in));
            act = 1;
            p_cyc = cyc + 1;
         end
      end
   end

   // starts at posedge+1 (or aligns to it); returns at posedge+1 just after the handshake edge
   task automatic issue(input bit align, input int op, input int rs, input int rd, input int imm);
      bit ok = 0;
      if (align) begin @(posedge clk_in); #1; end
      op_valid_in = 1; opcode_in = 4'(op); rs_in = 3'(rs); rd_in = 3'(rd); imm_in = 8'(imm);
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if (op_ready_out) ok = 1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL handshake_timeout actual=no_ready required=ready (t=%0t)", $time);
      end
      @(posedge clk_in); #1;
      op_valid_in = 0;
      opcode_in = 4'($urandom); rs_in = 3'($urandom); rd_in = 3'($urandom); imm_in = 8'($urandom);
   endtask

   // returns at the negedge of the first ready cycle (done cycle of the last op)
   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if (op_ready_out) ok = 1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL idle_timeout actual=busy required=ready (t=%0t)", $time);
      end
   endtask

   task automatic run(input int op, input int rs, input int rd, input int imm);
      issue(1, op, rs, rd, imm);
      wait_idle();
      chk("run_done_pulse", done_out, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
      rf[0] = 8'h05; rf[1] = 8'h01; rf[2] = 8'h01; rf[3] = 8'h20; rf[7] = 8'h33;
      for (int i = 0; i < 8; i++) mregs[i] = int'(rf[i]);
      repeat (3) @(posedge clk_in);
      #1 reset_in = 0;

      run(8, 0, 0, 8'h7F);
      run(3, 2, 0, 0);
      chk("lit_add_acc", acc_out, 8'h80);
      chk("lit_add_cz", {carry_out, zero_out}, 2'b00);

      run(8, 0, 0, 8'hFF);
      run(3, 1, 0, 0);
      chk("lit_add_wrap_acc", acc_out, 8'h00);
      chk("lit_add_wrap_cz", {carry_out, zero_out}, 2'b11);
      run(9, 1, 0, 0);
      chk("lit_adc_acc", acc_out, 8'h02);
      chk("lit_adc_cz", {carry_out, zero_out}, 2'b00);

      run(8, 0, 0, 8'h05);
      run(2, 0, 6, 0);
      chk("lit_st_r6", rf[6], 8'h05);
      run(1, 6, 0, 0);
      chk("lit_ld_r6", acc_out, 8'h05);

      run(8, 0, 0, 8'h03);
      run(4, 0, 0, 0);
      chk("lit_sub_acc", acc_out, 8'hFE);
      chk("lit_sub_borrow", carry_out, 1);

      run(8, 0, 0, 8'h01);
      run(11, 0, 0, 0);
      chk("lit_shr_acc", acc_out, 8'h00);
      chk("lit_shr_cz", {carry_out, zero_out}, 2'b11);

      run(14, 0, 0, 0);
      chk("lit_illegal_pulse", illegal_out, 1);
      chk("lit_illegal_acc", acc_out, 8'h00);
      chk("lit_illegal_cz", {carry_out, zero_out}, 2'b11);

      run(8, 0, 0, 8'h10);
      run(12, 3, 4, 0);
`ifdef ALU_EXEC_MUL_EN
      chk("lit_mul_acc", acc_out, 8'h00);
      chk("lit_mul_hi_r4", rf[4], 8'h02);
      chk("lit_mul_cz", {carry_out, zero_out}, 2'b11);
`else
      chk("lit_nomul_illegal", illegal_out, 1);
      chk("lit_nomul_acc", acc_out, 8'h10);
`endif

      // reset asserted mid-WB of a store must cancel the write
      run(8, 0, 0, 8'h5A);
      issue(1, 2, 0, 7, 0);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      chk("wb_en_before_reset", rf_write_en_out, 1);
      #2 reset_in = 1;
      #1;
      chk("reset_drops_we", rf_write_en_out, 0);
      chk("reset_ready", op_ready_out, 1);
      chk("reset_acc", acc_out, 8'h00);
      repeat (2) @(posedge clk_in);
      #1 reset_in = 0;
      @(negedge clk_in);
      chk("reset_r7_kept", rf[7], 8'h33);

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) @(posedge clk_in);
            #1;
         end
         issue(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      end
      wait_idle();
      repeat (2) @(negedge clk_in);
      for (int i = 0; i < 8; i++) chk("final_reg", rf[i], mregs[i]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
